sobel_gradient_engine: RTL and testbench
========================================

Name: sobel_gradient_engine

Overview:
- Parametrised successor to the 3x3 gradient block in the canny edge detection path.
- Takes one packed 3x3 pixel window and computes the Sobel Gx/Gy at the centre pixel.
- Produces a selectable-mode gradient magnitude (saturated to the output width), a quantised 2-bit direction sector for non-maximum suppression, and a threshold edge flag.
- Uses a multi-cycle FSM with the team's Enable/done handshake.

Parameters:
PIX_W, 24, pixel width in bits (unsigned)
OUT_W, PIX_W+3, magnitude output width; results above 2^OUT_W-1 saturate
MAG_MODE, 0, 0 = L1 (|Gx|+|Gy|); 1 = max(|Gx|,|Gy|) + (min(|Gx|,|Gy|)>>1)

Ports:
Clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
Enable  input  1  level request; sampled in IDLE
A  input  9*PIX_W  window; p[i][j] = A[(i*3+j)*PIX_W +: PIX_W], i = row 0..2, j = col 0..2
THR  input  OUT_W  edge threshold, sampled with A
GX  output  PIX_W+3  signed Sobel X result
GY  output  PIX_W+3  signed Sobel Y result
GM  output  OUT_W  gradient magnitude
DIR  output  2  0 = 0deg, 1 = 45deg, 2 = 90deg, 3 = 135deg
EDGE  output  1  GM >= THR
busy  output  1  high in all non-IDLE states
done  output  1  result valid

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset is synchronous, active-high, and takes priority over everything.
  - Reset forces state IDLE and sets GX = GY = GM = DIR = EDGE = busy = done = 0.
  - Asserting reset mid-operation aborts the computation; no done is produced.
- FSM states: IDLE, ROW0, ROW1, ROW2, ABS, MAG, DONE.
  - IDLE: if Enable == 1, latch A and THR into internal registers, clear the accumulators, go to ROW0. A and THR are ignored thereafter until the next IDLE.
  - ROWk (k = 0..2): add row k's weighted terms into the Gx/Gy accumulators (signed, PIX_W+3 bits). Weights are Kx = [-1 0 1; -2 0 2; -1 0 1] and Ky = [-1 -2 -1; 0 0 0; 1 2 1], rows indexed by i.
  - ABS: register |Gx| and |Gy| (PIX_W+2 bits) together with the sign bits.
  - MAG:
    - Compute the magnitude per MAG_MODE in PIX_W+3 bits, then saturate to OUT_W.
    - Compute DIR:
      - 5*|Gy| <= 2*|Gx| -> 0
      - else 5*|Gx| <= 2*|Gy| -> 2
      - else sign(Gx) == sign(Gy) -> 1
      - else 3
      - Gx = Gy = 0 gives DIR 0.
    - EDGE = (saturated GM >= latched THR).
    - Register GX, GY, GM, DIR, EDGE; set done <= 1; go to DONE.
  - DONE: outputs and done held stable while Enable == 1. When Enable == 0, clear done next edge and go to IDLE. Outputs retain their values until the next MAG or reset.
- Latency: Enable is sampled high at edge n; done is visible after edge n+5 (6 edges inclusive).
- Enable dropped mid-computation: the computation still completes. done pulses for exactly one cycle, then the FSM returns to IDLE.
- Back-to-back windows: a new window is accepted only after passing through IDLE, i.e. Enable must drop for at least one cycle after done.
- Arithmetic:
  - No overflow internally; the max |G| is 4*(2^PIX_W-1).
  - Saturation applies only to GM.
  - GX and GY are never truncated.
- busy = (state != IDLE); done = 1 only in DONE.

Test Plan:
- Reset: hold reset 10 cycles with Enable = 1 -> all outputs 0, busy = 0. Release reset -> done after 6 edges.
- Window {96,81,90,77,118,138,90,135,132} (MSB word first, so p[2][2] = 96, p[0][0] = 132), PIX_W = 24, THR = 200:
  - MAG_MODE = 0 -> GX = -158, GY = -144, GM = 302, DIR = 1, EDGE = 1.
  - MAG_MODE = 1 -> GM = 230.
- Flat window (all 50), THR = 1 -> GX = GY = GM = 0, DIR = 0, EDGE = 0, done at edge n+5.
- PIX_W = 8, OUT_W = 8, column 0 = 0, column 2 = 255 -> GX = 1020, GY = 0, GM = 255 (saturated), DIR = 0.
- Same configuration with row 0 = 0, row 2 = 255 -> GY = 1020, GX = 0, DIR = 2.
- Protocol:
  - Drop Enable in ROW1 -> done high for exactly 1 cycle.
  - Change A during ROW0 -> result reflects the latched A.
  - Assert reset in ABS -> no done, outputs 0.
  - Three back-to-back windows with a 1-cycle Enable gap -> each result is correct.

Source files
------------

// File: rtl/sobel_gradient_engine.sv
// rtl/sobel_gradient_engine.sv - multi-cycle 3x3 Sobel gradient, magnitude, direction and edge flag
module sobel_gradient_engine #(
    parameter int PIX_W    = 24,
    parameter int OUT_W    = PIX_W + 3,
    parameter int MAG_MODE = 0
) (
    input  logic                    Clock,
    input  logic                    reset,
    input  logic                    Enable,
    input  logic [9*PIX_W-1:0]      A,
    input  logic [OUT_W-1:0]        THR,
    output logic signed [PIX_W+2:0] GX,
    output logic signed [PIX_W+2:0] GY,
    output logic [OUT_W-1:0]        GM,
    output logic [1:0]              DIR,
    output logic                    EDGE,
    output logic                    busy,
    output logic                    done
);

    localparam int MW = PIX_W + 3;                  // signed gradient / raw magnitude width
    localparam int AW = PIX_W + 2;                  // absolute gradient width
    localparam int DW = PIX_W + 5;                  // holds 5*|G| for the sector test
    localparam int CW = (OUT_W > MW) ? OUT_W : MW;  // common width for the saturation compare

    typedef enum logic [2:0] {
        IDLE, ROW0, ROW1, ROW2, ABS, MAG, DONE
    } state_t;

    state_t state, next_state;

    logic [9*PIX_W-1:0]   win;
    logic [OUT_W-1:0]     thr_q;
    logic signed [MW-1:0] acc_gx, acc_gy;
    logic [AW-1:0]        abs_gx, abs_gy;
    logic                 sgn_gx, sgn_gy;

    logic [1:0]           row_idx;
    logic [PIX_W-1:0]     p_l, p_m, p_r;
    logic signed [MW-1:0] pl_s, pm_s, pr_s, diff, rsum, term_gx, term_gy;

    logic [AW-1:0]        mag_max, mag_min;
    logic [MW-1:0]        mag_raw;
    logic [CW-1:0]        mag_ext, sat_max;
    logic [OUT_W-1:0]     gm_sat;
    logic [DW-1:0]        five_x, five_y, two_x, two_y;
    logic [1:0]           dir_c;

    // State register; reset overrides everything and aborts any computation
    always_ff @(posedge Clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Fixed walk ROW0..MAG once started; DONE holds while Enable stays high
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Enable) next_state = ROW0;
            ROW0:    next_state = ROW1;
            ROW1:    next_state = ROW2;
            ROW2:    next_state = ABS;
            ABS:     next_state = MAG;
            MAG:     next_state = DONE;
            DONE:    if (!Enable) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Weighted contribution of the current window row to Gx and Gy
    always_comb begin
        row_idx = 2'd0;
        case (state)
            ROW1:    row_idx = 2'd1;
            ROW2:    row_idx = 2'd2;
            default: row_idx = 2'd0;
        endcase
        p_l  = win[(int'(row_idx) * 3 + 0) * PIX_W +: PIX_W];
        p_m  = win[(int'(row_idx) * 3 + 1) * PIX_W +: PIX_W];
        p_r  = win[(int'(row_idx) * 3 + 2) * PIX_W +: PIX_W];
        pl_s = signed'({3'b000, p_l});
        pm_s = signed'({3'b000, p_m});
        pr_s = signed'({3'b000, p_r});
        diff = pr_s - pl_s;
        rsum = pl_s + (pm_s <<< 1) + pr_s;
        term_gx = (row_idx == 2'd1) ? (diff <<< 1) : diff;
        if (state == ROW0)      term_gy = -rsum;
        else if (state == ROW2) term_gy = rsum;
        else                    term_gy = '0;
    end

    // Magnitude per mode, saturated to OUT_W, plus the quantised direction sector
    always_comb begin
        mag_max = (abs_gx >= abs_gy) ? abs_gx : abs_gy;
        mag_min = (abs_gx >= abs_gy) ? abs_gy : abs_gx;
        if (MAG_MODE == 0) mag_raw = MW'(abs_gx) + MW'(abs_gy);
        else               mag_raw = MW'(mag_max) + MW'(mag_min >> 1);
        mag_ext = CW'(mag_raw);
        sat_max = CW'({OUT_W{1'b1}});
        gm_sat  = OUT_W'((mag_ext > sat_max) ? sat_max : mag_ext);

        five_x = (DW'(abs_gx) << 2) + DW'(abs_gx);
        five_y = (DW'(abs_gy) << 2) + DW'(abs_gy);
        two_x  = DW'(abs_gx) << 1;
        two_y  = DW'(abs_gy) << 1;
        if (five_y <= two_x)       dir_c = 2'd0;
        else if (five_x <= two_y)  dir_c = 2'd2;
        else if (sgn_gx == sgn_gy) dir_c = 2'd1;
        else                       dir_c = 2'd3;
    end

    // Datapath: latch window, accumulate rows, take magnitudes, register results
    always_ff @(posedge Clock) begin
        if (reset) begin
            win    <= '0;
            thr_q  <= '0;
            acc_gx <= '0;
            acc_gy <= '0;
            abs_gx <= '0;
            abs_gy <= '0;
            sgn_gx <= 1'b0;
            sgn_gy <= 1'b0;
            GX     <= '0;
            GY     <= '0;
            GM     <= '0;
            DIR    <= 2'd0;
            EDGE   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Enable) begin
                        win    <= A;
                        thr_q  <= THR;
                        acc_gx <= '0;
                        acc_gy <= '0;
                    end
                end
                ROW0, ROW1, ROW2: begin
                    acc_gx <= acc_gx + term_gx;
                    acc_gy <= acc_gy + term_gy;
                end
                ABS: begin
                    abs_gx <= AW'(acc_gx[MW-1] ? -acc_gx : acc_gx);
                    abs_gy <= AW'(acc_gy[MW-1] ? -acc_gy : acc_gy);
                    sgn_gx <= acc_gx[MW-1];
                    sgn_gy <= acc_gy[MW-1];
                end
                MAG: begin
                    GX   <= acc_gx;
                    GY   <= acc_gy;
                    GM   <= gm_sat;
                    DIR  <= dir_c;
                    EDGE <= (gm_sat >= thr_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_gradient_engine.sv
// tb/tb_sobel_gradient_engine.sv - scoreboard bench for sobel_gradient_engine
module tb_sobel_gradient_engine;

    logic               Clock;
    logic               reset;
    logic               en24, en8;
    logic [9*24-1:0]    A24;
    logic [26:0]        THR24;
    logic [9*8-1:0]     A8;
    logic [7:0]         THR8;

    logic signed [26:0] GX0, GY0, GX1, GY1;
    logic [26:0]        GM0, GM1;
    logic [1:0]         DIR0, DIR1, DIR8;
    logic               EDGE0, EDGE1, EDGE8;
    logic               busy0, busy1, busy8;
    logic               done0, done1, done8;
    logic signed [10:0] GX8, GY8;
    logic [7:0]         GM8;

    int compared;
    int mismatched;

    typedef struct {
        longint gx;
        longint gy;
        longint gm;
        longint gm1;
        longint dir;
        longint edge_f;
    } exp_t;

    exp_t sb[$];

    sobel_gradient_engine #(.PIX_W(24), .OUT_W(27), .MAG_MODE(0)) dut0 (
        .Clock(Clock), .reset(reset), .Enable(en24), .A(A24), .THR(THR24),
        .GX(GX0), .GY(GY0), .GM(GM0), .DIR(DIR0), .EDGE(EDGE0), .busy(busy0), .done(done0)
    );

    sobel_gradient_engine #(.PIX_W(24), .OUT_W(27), .MAG_MODE(1)) dut1 (
        .Clock(Clock), .reset(reset), .Enable(en24), .A(A24), .THR(THR24),
        .GX(GX1), .GY(GY1), .GM(GM1), .DIR(DIR1), .EDGE(EDGE1), .busy(busy1), .done(done1)
    );

    sobel_gradient_engine #(.PIX_W(8), .OUT_W(8), .MAG_MODE(0)) dut8 (
        .Clock(Clock), .reset(reset), .Enable(en8), .A(A8), .THR(THR8),
        .GX(GX8), .GY(GY8), .GM(GM8), .DIR(DIR8), .EDGE(EDGE8), .busy(busy8), .done(done8)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input longint obs, input longint expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input int p[9], input int ow, input longint thr);
        exp_t   e;
        longint ax, ay, mx, mn, smax;
        e.gx = 0;
        e.gy = 0;
        for (int i = 0; i < 3; i++) begin
            longint w;
            w = (i == 1) ? 2 : 1;
            e.gx += w * (longint'(p[i*3+2]) - longint'(p[i*3+0]));
            e.gy += w * (longint'(p[6+i]) - longint'(p[i]));
        end
        ax   = (e.gx < 0) ? -e.gx : e.gx;
        ay   = (e.gy < 0) ? -e.gy : e.gy;
        mx   = (ax > ay) ? ax : ay;
        mn   = (ax > ay) ? ay : ax;
        smax = (longint'(1) << ow) - 1;
        e.gm  = (ax + ay > smax) ? smax : ax + ay;
        e.gm1 = (mx + mn / 2 > smax) ? smax : mx + mn / 2;
        if (5 * ay <= 2 * ax)             e.dir = 0;
        else if (5 * ax <= 2 * ay)        e.dir = 2;
        else if ((e.gx < 0) == (e.gy < 0)) e.dir = 1;
        else                              e.dir = 3;
        e.edge_f = (e.gm >= thr) ? 1 : 0;
        return e;
    endfunction

    task automatic load(input bit sel, input int p[9], input longint thr, input bit push);
        for (int k = 0; k < 9; k++) begin
            if (sel) A8[k*8 +: 8]    = 8'(p[k]);
            else     A24[k*24 +: 24] = 24'(p[k]);
        end
        if (sel) THR8 = 8'(thr);
        else     THR24 = 27'(thr);
        if (push) sb.push_back(model(p, sel ? 8 : 27, thr));
    endtask

    task automatic wait_done(input bit sel, output int cyc);
        cyc = 0;
        while (!(sel ? done8 : done0) && cyc < 30) begin
            @(negedge Clock);
            cyc++;
        end
        check("done_seen", sel ? done8 : done0, 1);
    endtask

    task automatic compare_result(input bit sel);
        exp_t e;
        e = sb.pop_front();
        if (sel) begin
            check("gx8", GX8, e.gx);
            check("gy8", GY8, e.gy);
            check("gm8", GM8, e.gm);
            check("dir8", DIR8, e.dir);
            check("edge8", EDGE8, e.edge_f);
        end else begin
            check("gx", GX0, e.gx);
            check("gy", GY0, e.gy);
            check("gm", GM0, e.gm);
            check("dir", DIR0, e.dir);
            check("edge", EDGE0, e.edge_f);
            check("gm_mode1", GM1, e.gm1);
            check("done_mode1", done1, 1);
        end
    endtask

    task automatic release_and_check(input bit sel);
        if (sel) en8 = 1'b0;
        else     en24 = 1'b0;
        @(negedge Clock);
        check("done_cleared", sel ? done8 : done0, 0);
        check("busy_cleared", sel ? busy8 : busy0, 0);
    endtask

    task automatic run(input bit sel, input int p[9], input longint thr);
        int cyc;
        load(sel, p, thr, 1'b1);
        if (sel) en8 = 1'b1;
        else     en24 = 1'b1;
        wait_done(sel, cyc);
        check("latency", cyc, 6);
        compare_result(sel);
        release_and_check(sel);
    endtask

    initial begin
        int w[9];
        int w2[9];
        int cyc;
        int seen;
        compared   = 0;
        mismatched = 0;
        reset = 1'b1;
        en24  = 1'b1;
        en8   = 1'b0;
        A24   = '0;
        THR24 = '0;
        A8    = '0;
        THR8  = '0;

        // Reset held with Enable high
        repeat (10) @(posedge Clock);
        @(negedge Clock);
        check("rst_gx", GX0, 0);
        check("rst_gy", GY0, 0);
        check("rst_gm", GM0, 0);
        check("rst_dir", DIR0, 0);
        check("rst_edge", EDGE0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_busy8", busy8, 0);

        // Reference window released straight out of reset
        w = '{132, 135, 90, 138, 118, 77, 90, 81, 96};
        load(1'b0, w, 200, 1'b1);
        reset = 1'b0;
        wait_done(1'b0, cyc);
        check("latency_after_reset", cyc, 6);
        check("ref_gx", GX0, -158);
        check("ref_gy", GY0, -144);
        check("ref_gm", GM0, 302);
        check("ref_dir", DIR0, 1);
        check("ref_edge", EDGE0, 1);
        check("ref_gm_mode1", GM1, 230);
        compare_result(1'b0);
        // Holding Enable keeps DONE and outputs stable
        @(negedge Clock);
        check("hold_done", done0, 1);
        check("hold_gm", GM0, 302);
        release_and_check(1'b0);

        // Threshold boundary: GM == THR and GM == THR-1
        run(1'b0, w, 302);
        run(1'b0, w, 303);

        // Flat window
        w = '{50, 50, 50, 50, 50, 50, 50, 50, 50};
        run(1'b0, w, 1);
        check("flat_gm", GM0, 0);

        // 135-degree sector
        w = '{100, 100, 200, 0, 0, 200, 0, 0, 100};
        run(1'b0, w, 5000);
        check("sector135", DIR0, 3);

        // 8-bit: vertical edge saturates GM
        w = '{0, 100, 255, 0, 100, 255, 0, 100, 255};
        run(1'b1, w, 200);
        check("col_gx8", GX8, 1020);
        check("col_gm8_sat", GM8, 255);
        check("col_dir8", DIR8, 0);

        // 8-bit: horizontal edge
        w = '{0, 0, 0, 77, 77, 77, 255, 255, 255};
        run(1'b1, w, 10);
        check("row_gy8", GY8, 1020);
        check("row_gx8", GX8, 0);
        check("row_dir8", DIR8, 2);

        // Enable dropped in ROW1: single-cycle done
        w = '{7, 900, 12345, 600000, 3, 16777215, 42, 0, 777};
        load(1'b0, w, 1000, 1'b1);
        en24 = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        check("busy_in_row1", busy0, 1);
        en24 = 1'b0;
        wait_done(1'b0, cyc);
        compare_result(1'b0);
        @(negedge Clock);
        check("pulse_done_low", done0, 0);
        check("pulse_busy_low", busy0, 0);

        // A changed during ROW0 must not affect the result
        w  = '{16777215, 0, 5, 1000, 2000, 3000, 0, 16777215, 9};
        w2 = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        load(1'b0, w, 50000, 1'b1);
        en24 = 1'b1;
        @(negedge Clock);
        load(1'b0, w2, 0, 1'b0);
        wait_done(1'b0, cyc);
        compare_result(1'b0);
        release_and_check(1'b0);

        // Reset asserted in ABS aborts with no done
        w = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
        load(1'b0, w, 0, 1'b0);
        en24 = 1'b1;
        repeat (4) @(negedge Clock);
        check("busy_in_abs", busy0, 1);
        reset = 1'b1;
        @(negedge Clock);
        en24  = 1'b0;
        reset = 1'b0;
        check("abort_gx", GX0, 0);
        check("abort_gm", GM0, 0);
        check("abort_dir", DIR0, 0);
        check("abort_edge", EDGE0, 0);
        check("abort_busy", busy0, 0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            if (done0) seen++;
        end
        check("abort_no_done", seen, 0);

        // Back-to-back random windows with a one-cycle Enable gap
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 9; k++) w[k] = int'($urandom_range(0, 32'h00FF_FFFF));
            run(1'b0, w, longint'($urandom_range(0, 32'h03FF_FFFF)));
        end
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 9; k++) w[k] = int'($urandom_range(0, 255));
            run(1'b1, w, longint'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
